// File: rtl/invol_arbiter_if.sv
// Handshake bundle between the involuntary-response units, the command engine
// and invol_arbiter. The slave modport is the arbiter's view.
interface invol_arbiter_if #(
  parameter int NUNITS    = 5,
  parameter int UNIT_BITS = 3
);
  logic [NUNITS-1:0]    invol_req;
  logic [NUNITS-1:0]    req_mask;
  logic                 engine_idle;
  logic [NUNITS-1:0]    unit_cmd_done;
  logic                 clear_err;
  logic [NUNITS-1:0]    invol_grant;
  logic                 engine_claim;
  logic [UNIT_BITS-1:0] sel_unit;
  logic                 busy;
  logic                 timeout_err;
  logic [UNIT_BITS-1:0] timeout_unit;

  modport slave (
    input  invol_req, req_mask, engine_idle, unit_cmd_done, clear_err,
    output invol_grant, engine_claim, sel_unit, busy, timeout_err, timeout_unit
  );

  modport master (
    output invol_req, req_mask, engine_idle, unit_cmd_done, clear_err,
    input  invol_grant, engine_claim, sel_unit, busy, timeout_err, timeout_unit
  );
endinterface

// File: rtl/invol_arbiter.sv
// Round-robin arbiter for unsolicited unit responses: grants one unit while the
// command engine is idle, holds until that unit's done, with a stuck-unit watchdog.
module invol_arbiter #(
  parameter int NUNITS       = 5,
  parameter int UNIT_BITS    = 3,
  parameter int TIMEOUT      = 65535,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic clk,
  input  logic rst_n,
  invol_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_HOLDOFF   = 2'd3
  } state_t;

  state_t                  r_state;
  logic [UNIT_BITS-1:0]    r_last;
  logic [UNIT_BITS-1:0]    r_sel;
  logic [NUNITS-1:0]       r_grant;
  logic                    r_claim;
  logic                    r_busy;
  logic                    r_err;
  logic [UNIT_BITS-1:0]    r_err_unit;
  logic [TIMEOUT_BITS-1:0] r_wd;

  logic [NUNITS-1:0]       w_elig;
  logic                    w_found;
  logic [UNIT_BITS-1:0]    w_pick;

  // Scan starts just after the last served unit and wraps modulo NUNITS.
  function automatic logic [UNIT_BITS:0] rr_pick(
    input logic [NUNITS-1:0]    elig,
    input logic [UNIT_BITS-1:0] last
  );
    logic                 found;
    logic [UNIT_BITS-1:0] pick;
    logic [UNIT_BITS-1:0] idx;
    int                   cand;
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NUNITS; i++) begin
      cand = (int'(last) + i) % NUNITS;
      idx  = UNIT_BITS'(cand);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end else begin
        found = found;
      end
    end
    return {found, pick};
  endfunction

  // Eligible set and round-robin winner for the IDLE arbitration.
  always_comb begin
    w_elig             = bus.invol_req & bus.req_mask;
    {w_found, w_pick}  = rr_pick(w_elig, r_last);
  end

  // Arbiter FSM with registered outputs, watchdog and sticky error capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last     <= UNIT_BITS'(NUNITS - 1);
      r_sel      <= '0;
      r_grant    <= '0;
      r_claim    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_err_unit <= '0;
      r_wd       <= '0;
    end else begin
      r_grant <= '0;
      r_claim <= 1'b0;
      if (bus.clear_err) begin
        r_err      <= 1'b0;
        r_err_unit <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.engine_idle && w_found) begin
            r_sel   <= w_pick;
            r_busy  <= 1'b1;
            r_state <= ST_GRANT;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_GRANT: begin
          // Request or engine may have gone away since arbitration; abort quietly.
          if (bus.engine_idle && bus.invol_req[r_sel]) begin
            r_grant <= {{(NUNITS-1){1'b0}}, 1'b1} << r_sel;
            r_claim <= 1'b1;
            r_wd    <= '0;
            r_state <= ST_WAIT_DONE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT_DONE: begin
          if (r_wd != {TIMEOUT_BITS{1'b1}}) begin
            r_wd <= r_wd + {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
          end
          if (bus.unit_cmd_done[r_sel]) begin
            r_last  <= r_sel;
            r_state <= ST_HOLDOFF;
          end else if (r_wd == TIMEOUT_BITS'(TIMEOUT - 1)) begin
            // A same-cycle clear wins and this expiry is not recorded.
            if (!bus.clear_err) begin
              r_err <= 1'b1;
              if (!r_err) begin
                r_err_unit <= r_sel;
              end
            end
            r_last  <= r_sel;
            r_state <= ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.invol_grant  = r_grant;
  assign bus.engine_claim = r_claim;
  assign bus.sel_unit     = r_sel;
  assign bus.busy         = r_busy;
  assign bus.timeout_err  = r_err;
  assign bus.timeout_unit = r_err_unit;

endmodule

// File: doc/invol_arbiter.md
Name: invol_arbiter

Overview:
- Round-robin arbiter for the involuntary-response path: up to NUNITS units raise invol_req when they have unsolicited data, such as endstop trigger state or a TMC UART read result.
- Grants exactly one unit at a time. A grant is issued only while the command engine is idle, and the arbiter holds the grant until that unit signals cmd_done.
- Sits between the units and the command engine, replacing the engine's fixed-priority scan. Adds fairness, a per-unit enable mask and a stuck-unit watchdog.

Parameters:
- NUNITS, 5, number of requesting units.
- UNIT_BITS, 3, width of unit index; must satisfy 2^UNIT_BITS >= NUNITS.
- TIMEOUT, 65535, max cycles from grant to cmd_done before the grant is forcibly released.
- TIMEOUT_BITS, 16, width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous active-low reset.
- invol_req, input, NUNITS: level request per unit.
- req_mask, input, NUNITS: 1 enables the unit; a masked unit is never granted.
- engine_idle, input, 1: command engine is in its idle state and no host message is pending.
- unit_cmd_done, input, NUNITS: per-unit done pulse.
- invol_grant, output, NUNITS: one-hot, one-cycle grant pulse to the selected unit.
- engine_claim, output, 1: one-cycle pulse, same cycle as invol_grant; engine enters response collection.
- sel_unit, output, UNIT_BITS: index of the granted unit; valid from GRANT until return to IDLE.
- busy, output, 1: high in GRANT, WAIT_DONE and HOLDOFF.
- timeout_err, output, 1: sticky flag, set on watchdog expiry.
- timeout_unit, output, UNIT_BITS: unit index captured at the first expiry.
- clear_err, input, 1: clears timeout_err and timeout_unit.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=IDLE; all outputs 0.
  - last_grant=NUNITS-1, so unit 0 wins first.
  - Watchdog counter=0.
  - Reset mid-grant drops the grant with no done required.
- Eligible set E = invol_req & req_mask.
- IDLE:
  - If engine_idle and E!=0: pick the first set bit of E scanning last_grant+1, last_grant+2, ... modulo NUNITS.
  - Register the pick into sel_unit and go to GRANT. Otherwise stay in IDLE.
- GRANT (one cycle):
  - If engine_idle=1 and invol_req[sel_unit]=1: pulse invol_grant[sel_unit] and engine_claim, clear the watchdog, go to WAIT_DONE.
  - Otherwise abort to IDLE with no pulse. last_grant is unchanged.
- WAIT_DONE:
  - Watchdog increments each cycle.
  - unit_cmd_done[sel_unit]=1: last_grant<=sel_unit, go to HOLDOFF.
  - Otherwise, watchdog==TIMEOUT-1: set timeout_err. Capture timeout_unit only if timeout_err was 0. Then last_grant<=sel_unit, go to HOLDOFF.
  - unit_cmd_done on any other unit is ignored.
- HOLDOFF (one cycle):
  - Always returns to IDLE.
  - Gives a pending host message one cycle to lower engine_idle, so host commands win over back-to-back involuntary traffic.
- Latency: req rising with engine_idle=1 at edge t gives grant at edge t+2. Minimum spacing between consecutive grants is 4 cycles after done.
- engine_idle is not sampled in WAIT_DONE or HOLDOFF.
- clear_err has priority over a same-cycle timeout set; that timeout is lost.
- Requests dropped during WAIT_DONE have no effect; the arbiter still waits for done or timeout.
- req_mask changes take effect at the next IDLE arbitration.
- Widths: the round-robin index wraps modulo NUNITS, not 2^UNIT_BITS. The watchdog saturates and never wraps.

Test Plan:
- Reset then invol_req=5'b00100, mask=all, engine_idle=1 → invol_grant=5'b00100 and engine_claim exactly 2 cycles after the req edge; sel_unit=2; busy=1 until 1 cycle after unit_cmd_done[2].
- invol_req=5'b11111 held, done returned 3 cycles after each grant → grant order 0,1,2,3,4,0; no unit is granted twice within 5 grants.
- invol_req=5'b00011, req_mask=5'b11110 → only unit 1 is ever granted. Mask set to 5'b11111 mid-WAIT_DONE → unit 0 granted on the next arbitration.
- engine_idle drops in the GRANT cycle → no grant pulse, return to IDLE; grant issued once engine_idle=1 again; last_grant unchanged (same unit wins).
- TIMEOUT=20, unit 3 granted, never done → at cycle 20 after grant: timeout_err=1, timeout_unit=3, return to IDLE; a following req on unit 4 is granted. clear_err → flags return to 0.
- rst_n=0 during WAIT_DONE → next cycle all outputs 0; req on unit 0 and unit 3 → unit 0 granted first.
